// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control unit and its datapath.
// The master side is the control unit: it reads the instruction fields and the
// ALU zero flag, and drives every mux select and write enable.
interface multicycle_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] ALUcontrol;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       RegDst;
  logic       MemtoReg;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       PCWrite;
  logic       Branch;
  logic       PCEn;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output ALUcontrol, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg,
           IRWrite, MemWrite, RegWrite, PCWrite, Branch, PCEn, state
  );

  modport slave (
    output op, funct, zero,
    input  ALUcontrol, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg,
           IRWrite, MemWrite, RegWrite, PCWrite, Branch, PCEn, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, decodes the ALU
// operation and combines Branch with the ALU zero flag into PCEn.
module multicycle_control (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       pc_write;
  logic       branch;

  // State register; reset drops straight back to FETCH, aborting any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  // Moore outputs per state; only EXECUTE also looks at funct.
  always_comb begin
    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      DECODE:   alu_src_b = 2'b11;
      MEMADR, ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD:    iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        case (bus.funct)
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b101010: alu_control = ALU_SLT;
          default:   alu_control = ALU_ADD;
        endcase
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      ADDIWB:   reg_write = 1'b1;
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by rst_n so nothing writes while reset is held, even
  // though the register already sits in FETCH.
  assign bus.IRWrite    = ir_write  & rst_n;
  assign bus.MemWrite   = mem_write & rst_n;
  assign bus.RegWrite   = reg_write & rst_n;
  assign bus.PCWrite    = pc_write  & rst_n;
  assign bus.Branch     = branch    & rst_n;
  assign bus.PCEn       = (pc_write | (branch & bus.zero)) & rst_n;
  assign bus.ALUcontrol = alu_control;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.PCSrc      = pc_src;
  assign bus.IorD       = iord;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: walks each instruction class
// through its state sequence and checks state, enables and selects per cycle.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // en = {IRWrite, MemWrite, RegWrite, PCWrite, Branch, PCEn}
  wire [5:0]  en  = {bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.PCWrite, bus.Branch, bus.PCEn};
  // sel = {ALUcontrol[2:0], ALUSrcA, ALUSrcB[1:0], PCSrc[1:0], IorD, RegDst, MemtoReg}
  wire [10:0] sel = {bus.ALUcontrol, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.IorD, bus.RegDst, bus.MemtoReg};

  localparam logic [5:0]  EN_NONE    = 6'b000000;
  localparam logic [5:0]  EN_FETCH   = 6'b100101;
  localparam logic [5:0]  EN_REGW    = 6'b001000;
  localparam logic [5:0]  EN_MEMW    = 6'b010000;
  localparam logic [5:0]  EN_JUMP    = 6'b000101;

  localparam logic [10:0] SEL_FETCH  = 11'b010_0_01_00_000;
  localparam logic [10:0] SEL_DECODE = 11'b010_0_11_00_000;
  localparam logic [10:0] SEL_ADR    = 11'b010_1_10_00_000;
  localparam logic [10:0] SEL_MEMRD  = 11'b010_0_00_00_100;
  localparam logic [10:0] SEL_MEMWB  = 11'b010_0_00_00_001;
  localparam logic [10:0] SEL_MEMWR  = 11'b010_0_00_00_100;
  localparam logic [10:0] SEL_ALUWB  = 11'b010_0_00_00_010;
  localparam logic [10:0] SEL_PLAIN  = 11'b010_0_00_00_000;
  localparam logic [10:0] SEL_BRANCH = 11'b110_1_00_01_000;
  localparam logic [10:0] SEL_JUMP   = 11'b010_0_00_10_000;

  // Advance one clock and sample just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.op = 6'b0;
    bus.funct = 6'b0;
    bus.zero = 1'b0;
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.state !== 4'd0) begin failures++; $display("[TB] FAIL reset state: got %0d expected 0", bus.state); end
      checks++;
      if (en !== EN_NONE) begin failures++; $display("[TB] FAIL reset enables: got %b expected %b", en, EN_NONE); end
      checks++;
      if (sel !== SEL_FETCH) begin failures++; $display("[TB] FAIL reset selects: got %b expected %b", sel, SEL_FETCH); end
      if (k == 0) step();
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0) begin failures++; $display("[TB] FAIL release state: got %0d expected 0", bus.state); end
    checks++;
    if (en !== EN_FETCH) begin failures++; $display("[TB] FAIL release enables: got %b expected %b", en, EN_FETCH); end
  endtask

  task automatic test_lw();
    logic [3:0]  exp_st[6]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [5:0]  exp_en[6]  = '{EN_FETCH, EN_NONE, EN_NONE, EN_NONE, EN_REGW, EN_FETCH};
    logic [10:0] exp_sel[6] = '{SEL_FETCH, SEL_DECODE, SEL_ADR, SEL_MEMRD, SEL_MEMWB, SEL_FETCH};
    bus.op = 6'b100011;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.state !== exp_st[i]) begin failures++; $display("[TB] FAIL lw state cyc %0d: got %0d expected %0d", i, bus.state, exp_st[i]); end
      checks++;
      if (en !== exp_en[i]) begin failures++; $display("[TB] FAIL lw enables cyc %0d: got %b expected %b", i, en, exp_en[i]); end
      checks++;
      if (sel !== exp_sel[i]) begin failures++; $display("[TB] FAIL lw selects cyc %0d: got %b expected %b", i, sel, exp_sel[i]); end
      if (i < 5) step();
    end
  endtask

  task automatic test_rtype(input logic [5:0] f, input logic [2:0] alu);
    logic [3:0]  exp_st[5]  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [5:0]  exp_en[5]  = '{EN_FETCH, EN_NONE, EN_NONE, EN_REGW, EN_FETCH};
    logic [10:0] exp_sel[5] = '{SEL_FETCH, SEL_DECODE, {alu, 8'b1_00_00_000}, SEL_ALUWB, SEL_FETCH};
    bus.op = 6'b000000;
    bus.funct = f;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.state !== exp_st[i]) begin failures++; $display("[TB] FAIL rtype %b state cyc %0d: got %0d expected %0d", f, i, bus.state, exp_st[i]); end
      checks++;
      if (en !== exp_en[i]) begin failures++; $display("[TB] FAIL rtype %b enables cyc %0d: got %b expected %b", f, i, en, exp_en[i]); end
      checks++;
      if (sel !== exp_sel[i]) begin failures++; $display("[TB] FAIL rtype %b selects cyc %0d: got %b expected %b", f, i, sel, exp_sel[i]); end
      if (i < 4) step();
    end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0]  exp_st[4]  = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [5:0]  exp_en[4]  = '{EN_FETCH, EN_NONE, {5'b00001, z}, EN_FETCH};
    logic [10:0] exp_sel[4] = '{SEL_FETCH, SEL_DECODE, SEL_BRANCH, SEL_FETCH};
    bus.op = 6'b000100;
    bus.zero = z;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.state !== exp_st[i]) begin failures++; $display("[TB] FAIL beq z=%0b state cyc %0d: got %0d expected %0d", z, i, bus.state, exp_st[i]); end
      checks++;
      if (en !== exp_en[i]) begin failures++; $display("[TB] FAIL beq z=%0b enables cyc %0d: got %b expected %b", z, i, en, exp_en[i]); end
      checks++;
      if (sel !== exp_sel[i]) begin failures++; $display("[TB] FAIL beq z=%0b selects cyc %0d: got %b expected %b", z, i, sel, exp_sel[i]); end
      if (i < 3) step();
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_sw_jump();
    logic [3:0]  sw_st[5]  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic [5:0]  sw_en[5]  = '{EN_FETCH, EN_NONE, EN_NONE, EN_MEMW, EN_FETCH};
    logic [10:0] sw_sel[5] = '{SEL_FETCH, SEL_DECODE, SEL_ADR, SEL_MEMWR, SEL_FETCH};
    logic [3:0]  j_st[4]   = '{4'd0, 4'd1, 4'd11, 4'd0};
    logic [5:0]  j_en[4]   = '{EN_FETCH, EN_NONE, EN_JUMP, EN_FETCH};
    logic [10:0] j_sel[4]  = '{SEL_FETCH, SEL_DECODE, SEL_JUMP, SEL_FETCH};
    bus.op = 6'b101011;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.state !== sw_st[i]) begin failures++; $display("[TB] FAIL sw state cyc %0d: got %0d expected %0d", i, bus.state, sw_st[i]); end
      checks++;
      if (en !== sw_en[i]) begin failures++; $display("[TB] FAIL sw enables cyc %0d: got %b expected %b", i, en, sw_en[i]); end
      checks++;
      if (sel !== sw_sel[i]) begin failures++; $display("[TB] FAIL sw selects cyc %0d: got %b expected %b", i, sel, sw_sel[i]); end
      if (i < 4) step();
    end
    bus.op = 6'b000010;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.state !== j_st[i]) begin failures++; $display("[TB] FAIL j state cyc %0d: got %0d expected %0d", i, bus.state, j_st[i]); end
      checks++;
      if (en !== j_en[i]) begin failures++; $display("[TB] FAIL j enables cyc %0d: got %b expected %b", i, en, j_en[i]); end
      checks++;
      if (sel !== j_sel[i]) begin failures++; $display("[TB] FAIL j selects cyc %0d: got %b expected %b", i, sel, j_sel[i]); end
      if (i < 3) step();
    end
  endtask

  task automatic test_addi();
    logic [3:0]  exp_st[5]  = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    logic [5:0]  exp_en[5]  = '{EN_FETCH, EN_NONE, EN_NONE, EN_REGW, EN_FETCH};
    logic [10:0] exp_sel[5] = '{SEL_FETCH, SEL_DECODE, SEL_ADR, SEL_PLAIN, SEL_FETCH};
    bus.op = 6'b001000;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.state !== exp_st[i]) begin failures++; $display("[TB] FAIL addi state cyc %0d: got %0d expected %0d", i, bus.state, exp_st[i]); end
      checks++;
      if (en !== exp_en[i]) begin failures++; $display("[TB] FAIL addi enables cyc %0d: got %b expected %b", i, en, exp_en[i]); end
      checks++;
      if (sel !== exp_sel[i]) begin failures++; $display("[TB] FAIL addi selects cyc %0d: got %b expected %b", i, sel, exp_sel[i]); end
      if (i < 4) step();
    end
  endtask

  task automatic test_unknown_op();
    logic [3:0]  exp_st[3]  = '{4'd0, 4'd1, 4'd0};
    logic [5:0]  exp_en[3]  = '{EN_FETCH, EN_NONE, EN_FETCH};
    logic [10:0] exp_sel[3] = '{SEL_FETCH, SEL_DECODE, SEL_FETCH};
    bus.op = 6'b111111;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.state !== exp_st[i]) begin failures++; $display("[TB] FAIL nop state cyc %0d: got %0d expected %0d", i, bus.state, exp_st[i]); end
      checks++;
      if (en !== exp_en[i]) begin failures++; $display("[TB] FAIL nop enables cyc %0d: got %b expected %b", i, en, exp_en[i]); end
      checks++;
      if (sel !== exp_sel[i]) begin failures++; $display("[TB] FAIL nop selects cyc %0d: got %b expected %b", i, sel, exp_sel[i]); end
      if (i < 2) step();
    end
  endtask

  task automatic test_reset_mid_memwr();
    bus.op = 6'b101011;
    #1;
    step();
    step();
    step();
    checks++;
    if (bus.state !== 4'd5) begin failures++; $display("[TB] FAIL midreset pre state: got %0d expected 5", bus.state); end
    checks++;
    if (en !== EN_MEMW) begin failures++; $display("[TB] FAIL midreset pre enables: got %b expected %b", en, EN_MEMW); end
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.state !== 4'd0) begin failures++; $display("[TB] FAIL midreset state %0d: got %0d expected 0", k, bus.state); end
      checks++;
      if (en !== EN_NONE) begin failures++; $display("[TB] FAIL midreset enables %0d: got %b expected %b", k, en, EN_NONE); end
      checks++;
      if (sel !== SEL_FETCH) begin failures++; $display("[TB] FAIL midreset selects %0d: got %b expected %b", k, sel, SEL_FETCH); end
      if (k == 0) step();
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (en !== EN_FETCH) begin failures++; $display("[TB] FAIL midreset release enables: got %b expected %b", en, EN_FETCH); end
    step();
    checks++;
    if (bus.state !== 4'd1) begin failures++; $display("[TB] FAIL midreset restart state: got %0d expected 1", bus.state); end
  endtask

  // Scenarios run back to back, each starting in FETCH where the last ended.
  initial begin
    $display("[TB] starting multicycle_control tests");
    test_reset();
    test_lw();
    test_rtype(6'b101010, 3'd7);
    test_rtype(6'b100010, 3'd6);
    test_rtype(6'b100100, 3'd0);
    test_rtype(6'b100101, 3'd1);
    test_rtype(6'b100000, 3'd2);
    test_rtype(6'b000000, 3'd2);
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw_jump();
    test_addi();
    test_unknown_op();
    test_reset_mid_memwr();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
